// File: rtl/pdu_ring_ctrl.sv
// Ring-buffer controller between the PDU generator write port and the ring RAM.
// Optional PDU/flit statistics counters are built when PDU_RING_STATS_EN is defined.
module pdu_ring_ctrl #(
    parameter int PDU_AWIDTH = 12,
    parameter int AF_MARGIN  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [513:0]          wr_data,
    input  logic [PDU_AWIDTH-1:0] wr_addr,
    input  logic                  wr_en,
    output logic [PDU_AWIDTH-1:0] wr_base_addr,
    output logic                  almost_full,
    input  logic                  update_valid,
    input  logic [PDU_AWIDTH-1:0] update_size,
    input  logic                  head_wr_valid,
    input  logic [PDU_AWIDTH-1:0] head_wr_ptr,
    output logic                  ram_wr_en,
    output logic [PDU_AWIDTH-1:0] ram_wr_addr,
    output logic [513:0]          ram_wr_data,
    output logic                  tail_valid,
    output logic [PDU_AWIDTH-1:0] tail_ptr,
    input  logic                  tail_ready,
    output logic [PDU_AWIDTH-1:0] occupancy,
    output logic [2:0]            err_flags
`ifdef PDU_RING_STATS_EN
    ,
    output logic [31:0]           stat_pdu_cnt,
    output logic [31:0]           stat_flit_cnt
`endif
);

    // All-ones pointer value equals DEPTH-1, the usable capacity of the ring.
    localparam logic [PDU_AWIDTH-1:0] MAX_PTR = '1;

    typedef enum logic {
        DB_IDLE,
        DB_NOTIFY
    } db_state_t;

    logic [PDU_AWIDTH-1:0] tail_reg;
    logic [PDU_AWIDTH-1:0] head_reg;
    logic [PDU_AWIDTH-1:0] tail_next;
    logic [PDU_AWIDTH-1:0] head_next;
    logic [PDU_AWIDTH-1:0] occ;
    logic [PDU_AWIDTH-1:0] free;
    logic [PDU_AWIDTH-1:0] free_next;
    logic [PDU_AWIDTH-1:0] wr_offset;
    logic [PDU_AWIDTH-1:0] head_advance;
    logic                  wr_legal;
    logic                  commit_ok;
    logic                  commit_nz;
    logic                  head_ok;
    logic                  almost_full_next;
    logic [2:0]            err_set;

    logic                  almost_full_reg;
    logic [PDU_AWIDTH-1:0] occupancy_reg;
    logic                  ram_wr_en_reg;
    logic [PDU_AWIDTH-1:0] ram_wr_addr_reg;
    logic [513:0]          ram_wr_data_reg;
    db_state_t             db_state_reg;
    logic                  tail_valid_reg;
    logic [PDU_AWIDTH-1:0] tail_ptr_reg;

    // Legality of writes, commits and head moves all use the current-cycle pointers.
    assign occ          = tail_reg - head_reg;
    assign free         = MAX_PTR - occ;
    assign wr_offset    = wr_addr - tail_reg;
    assign head_advance = head_wr_ptr - head_reg;

    assign wr_legal  = wr_offset < free;
    assign commit_ok = update_valid && (update_size <= free);
    assign commit_nz = commit_ok && (update_size != '0);
    assign head_ok   = head_wr_valid && (head_advance <= occ);

    assign tail_next = commit_ok ? (tail_reg + update_size) : tail_reg;
    assign head_next = head_ok ? head_wr_ptr : head_reg;

    assign free_next        = MAX_PTR - (tail_next - head_next);
    assign almost_full_next = int'(free_next) < AF_MARGIN;

    assign err_set = {head_wr_valid && !head_ok,
                      update_valid && !commit_ok,
                      wr_en && !wr_legal};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tail_reg        <= '0;
            head_reg        <= '0;
            almost_full_reg <= 1'b0;
            occupancy_reg   <= '0;
        end else begin
            tail_reg        <= tail_next;
            head_reg        <= head_next;
            almost_full_reg <= almost_full_next;
            occupancy_reg   <= tail_next - head_next;
        end
    end

    // Write path: one-cycle registered forward of legal writes only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_wr_en_reg   <= 1'b0;
            ram_wr_addr_reg <= '0;
        end else begin
            ram_wr_en_reg   <= wr_en && wr_legal;
            ram_wr_addr_reg <= wr_addr;
        end
    end

    // Data is qualified by ram_wr_en, so it needs no reset.
    always_ff @(posedge clk) begin
        ram_wr_data_reg <= wr_data;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_err
            logic sticky_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sticky_reg <= 1'b0;
                end else if (err_set[gi]) begin
                    sticky_reg <= 1'b1;
                end
            end
            assign err_flags[gi] = sticky_reg;
        end
    endgenerate

    // Coalescing doorbell: a pending notification always carries the newest tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_state_reg   <= DB_IDLE;
            tail_valid_reg <= 1'b0;
            tail_ptr_reg   <= '0;
        end else begin
            case (db_state_reg)
                DB_IDLE: begin
                    if (commit_nz) begin
                        db_state_reg   <= DB_NOTIFY;
                        tail_valid_reg <= 1'b1;
                        tail_ptr_reg   <= tail_next;
                    end
                end
                DB_NOTIFY: begin
                    if (commit_nz) begin
                        tail_ptr_reg <= tail_next;
                    end else if (tail_ready) begin
                        db_state_reg   <= DB_IDLE;
                        tail_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    db_state_reg   <= DB_IDLE;
                    tail_valid_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef PDU_RING_STATS_EN
    logic [31:0] stat_pdu_cnt_reg;
    logic [31:0] stat_flit_cnt_reg;
    logic [32:0] flit_sum;

    assign flit_sum = {1'b0, stat_flit_cnt_reg} + 33'(update_size);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pdu_cnt_reg  <= '0;
            stat_flit_cnt_reg <= '0;
        end else if (commit_nz) begin
            if (stat_pdu_cnt_reg != 32'hFFFF_FFFF) begin
                stat_pdu_cnt_reg <= stat_pdu_cnt_reg + 32'd1;
            end
            stat_flit_cnt_reg <= flit_sum[32] ? 32'hFFFF_FFFF : flit_sum[31:0];
        end
    end

    assign stat_pdu_cnt  = stat_pdu_cnt_reg;
    assign stat_flit_cnt = stat_flit_cnt_reg;
`endif

    assign wr_base_addr = tail_reg;
    assign almost_full  = almost_full_reg;
    assign occupancy    = occupancy_reg;
    assign ram_wr_en    = ram_wr_en_reg;
    assign ram_wr_addr  = ram_wr_addr_reg;
    assign ram_wr_data  = ram_wr_data_reg;
    assign tail_valid   = tail_valid_reg;
    assign tail_ptr     = tail_ptr_reg;

endmodule

// File: tb/tb_pdu_ring_ctrl.sv
// Scoreboard bench for pdu_ring_ctrl on a 16-slot ring with AF_MARGIN = 4.
// Driver pushes expected responses; a separate monitor pops and compares.
module tb_pdu_ring_ctrl;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFM   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [513:0]  wr_data = '0;
    logic [AW-1:0] wr_addr = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_base_addr;
    logic          almost_full;
    logic          update_valid = 1'b0;
    logic [AW-1:0] update_size = '0;
    logic          head_wr_valid = 1'b0;
    logic [AW-1:0] head_wr_ptr = '0;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [513:0]  ram_wr_data;
    logic          tail_valid;
    logic [AW-1:0] tail_ptr;
    logic          tail_ready = 1'b0;
    logic [AW-1:0] occupancy;
    logic [2:0]    err_flags;
`ifdef PDU_RING_STATS_EN
    logic [31:0]   stat_pdu_cnt;
    logic [31:0]   stat_flit_cnt;
`endif

    always #5 clk = ~clk;

    pdu_ring_ctrl #(.PDU_AWIDTH(AW), .AF_MARGIN(AFM)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
        .wr_base_addr(wr_base_addr), .almost_full(almost_full),
        .update_valid(update_valid), .update_size(update_size),
        .head_wr_valid(head_wr_valid), .head_wr_ptr(head_wr_ptr),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .tail_valid(tail_valid), .tail_ptr(tail_ptr), .tail_ready(tail_ready),
        .occupancy(occupancy), .err_flags(err_flags)
`ifdef PDU_RING_STATS_EN
        , .stat_pdu_cnt(stat_pdu_cnt), .stat_flit_cnt(stat_flit_cnt)
`endif
    );

    typedef struct {
        logic          wen;
        logic [AW-1:0] occ;
        logic          af;
        logic [AW-1:0] base;
        logic [2:0]    err;
        logic          tv;
        logic [AW-1:0] tp;
        logic [31:0]   pc;
        logic [31:0]   fc;
    } snap_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [513:0]  d;
    } wr_t;

    snap_t sq[$];
    wr_t   wq[$];

    int compared   = 0;
    int mismatched = 0;
    bit mon_en     = 1'b0;

    // Reference model: ring pointers, sticky errors, pending doorbell, counters.
    int unsigned m_tail, m_head, m_dbv, m_pc, m_fc;
    bit          m_pend;
    logic [2:0]  m_err;

    task automatic chk(input string name, input logic [513:0] act, input logic [513:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_tail = 0; m_head = 0; m_dbv = 0; m_pc = 0; m_fc = 0;
        m_pend = 1'b0; m_err = 3'b000;
    endfunction

    function automatic logic [513:0] rand_flit();
        logic [543:0] t;
        for (int k = 0; k < 17; k++) t[k*32 +: 32] = $urandom;
        return t[513:0];
    endfunction

    // Drive one cycle of inputs and record what the DUT must show after the next edge.
    task automatic apply(input bit wen, input int unsigned wa, input bit uv, input int unsigned us,
                         input bit hv, input int unsigned hp, input bit tr);
        int unsigned occ, free, nt, nh;
        bit          cok, wlegal;
        snap_t       s;
        wr_t         w;
        wa = wa % DEPTH; us = us % DEPTH; hp = hp % DEPTH;
        wr_en = wen; wr_addr = AW'(wa); wr_data = rand_flit();
        update_valid = uv; update_size = AW'(us);
        head_wr_valid = hv; head_wr_ptr = AW'(hp); tail_ready = tr;

        occ  = (m_tail + DEPTH - m_head) % DEPTH;
        free = DEPTH - 1 - occ;
        wlegal = wen && (((wa + DEPTH - m_tail) % DEPTH) < free);
        if (wlegal) begin
            w.a = AW'(wa); w.d = wr_data;
            wq.push_back(w);
        end else if (wen) m_err[0] = 1'b1;

        nt = m_tail; cok = 1'b0;
        if (uv) begin
            if (us <= free) begin
                nt  = (m_tail + us) % DEPTH;
                cok = (us != 0);
            end else m_err[1] = 1'b1;
        end
        nh = m_head;
        if (hv) begin
            if (((hp + DEPTH - m_head) % DEPTH) <= occ) nh = hp;
            else m_err[2] = 1'b1;
        end
        if (cok) begin
            m_pend = 1'b1; m_dbv = nt;
            if (m_pc != 32'hFFFF_FFFF) m_pc++;
            m_fc = (longint'(m_fc) + us > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_fc + us;
        end else if (m_pend && tr) m_pend = 1'b0;
        m_tail = nt; m_head = nh;

        s.wen  = wlegal;
        s.occ  = AW'((m_tail + DEPTH - m_head) % DEPTH);
        s.af   = (DEPTH - 1 - int'(s.occ)) < AFM;
        s.base = AW'(m_tail);
        s.err  = m_err;
        s.tv   = m_pend;
        s.tp   = AW'(m_dbv);
        s.pc   = m_pc;
        s.fc   = m_fc;
        sq.push_back(s);
    endtask

    task automatic step(input bit wen, input int unsigned wa, input bit uv, input int unsigned us,
                        input bit hv, input int unsigned hp, input bit tr);
        @(negedge clk);
        apply(wen, wa, uv, us, hv, hp, tr);
    endtask

    task automatic idle(input int n, input bit tr);
        repeat (n) step(0, 0, 0, 0, 0, 0, tr);
    endtask

    // Asserts reset between edges, checks the immediate effect, then releases.
    task automatic do_reset();
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("rst_ram_wr_en", ram_wr_en, 0);
        chk("rst_tail_valid", tail_valid, 0);
        chk("rst_tail_ptr", tail_ptr, 0);
        chk("rst_wr_base_addr", wr_base_addr, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_err_flags", err_flags, 0);
`ifdef PDU_RING_STATS_EN
        chk("rst_stat_pdu", stat_pdu_cnt, 0);
        chk("rst_stat_flit", stat_flit_cnt, 0);
`endif
        wq.delete();
        sq.delete();
        model_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: one snapshot per cycle, one write entry per ram_wr_en pulse.
    initial begin
        snap_t s;
        wr_t   w;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (sq.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL snapshot_queue: got empty expected entry at %0t", $time);
                end else begin
                    s = sq.pop_front();
                    chk("ram_wr_en", ram_wr_en, s.wen);
                    chk("occupancy", occupancy, s.occ);
                    chk("almost_full", almost_full, s.af);
                    chk("wr_base_addr", wr_base_addr, s.base);
                    chk("err_flags", err_flags, s.err);
                    chk("tail_valid", tail_valid, s.tv);
                    chk("tail_ptr", tail_ptr, s.tp);
`ifdef PDU_RING_STATS_EN
                    chk("stat_pdu_cnt", stat_pdu_cnt, s.pc);
                    chk("stat_flit_cnt", stat_flit_cnt, s.fc);
`endif
                end
                if (ram_wr_en) begin
                    if (wq.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL ram_write: got write at %0h expected none at %0t", ram_wr_addr, $time);
                    end else begin
                        w = wq.pop_front();
                        chk("ram_wr_addr", ram_wr_addr, w.a);
                        chk("ram_wr_data", ram_wr_data, w.d);
                    end
                end
            end
        end
    end

    initial begin
        int unsigned occ, free;
        model_reset();
        do_reset();

        // One PDU: three payload writes then commit of four.
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0);
        step(0, 0, 1, 4, 0, 0, 0);
        idle(2, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(1, 0);

        // Wrap: bring head and tail to 14, then a PDU straddling the end.
        do_reset();
        step(0, 0, 1, 14, 0, 0, 1);
        step(0, 0, 0, 0, 1, 14, 1);
        step(1, 15, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 1);
        step(0, 0, 1, 4, 0, 0, 0);
        idle(2, 0);

        // Full / almost_full and an oversize commit.
        do_reset();
        step(0, 0, 1, 12, 0, 0, 0);
        idle(1, 0);
        step(0, 0, 1, 4, 0, 0, 0);
        step(0, 0, 0, 0, 1, 8, 0);
        idle(2, 1);

        // Doorbell coalescing, then illegal write and head update.
        do_reset();
        step(0, 0, 1, 2, 0, 0, 0);
        step(0, 0, 1, 2, 0, 0, 0);
        step(0, 0, 1, 2, 0, 0, 0);
        idle(2, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(1, 0);
        step(1, 5, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 8, 0);
        idle(2, 0);

        // Reset mid-PDU with a doorbell pending and a write in flight.
        do_reset();
        step(0, 0, 1, 2, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0);
        do_reset();
        idle(1, 0);

        // Randomized traffic, including simultaneous commit and head update.
        repeat (6) begin
            do_reset();
            repeat (150) begin
                occ  = (m_tail + DEPTH - m_head) % DEPTH;
                free = DEPTH - 1 - occ;
                step(($urandom % 2) == 1,
                     (($urandom % 8) == 0) ? $urandom : m_tail + $urandom_range(0, free + 1),
                     ($urandom % 3) == 0,
                     $urandom_range(0, (free + 1 > 15) ? 15 : free + 1),
                     ($urandom % 4) == 0,
                     m_head + $urandom_range(0, occ + 1),
                     ($urandom % 2) == 1);
            end
        end

        @(posedge clk);
        #2;
        chk("write_queue_drained", wq.size(), 0);
        chk("snapshot_queue_drained", sq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pdu_ring_ctrl.md
Name: pdu_ring_ctrl

Overview:
- Ring-buffer controller directly downstream of the PDU generator's PCIe ring-buffer write port.
- Accepts flit writes into the reserved region past the committed tail and forwards them to the ring RAM.
- Advances the committed tail on each PDU commit (update_valid / update_size) and tracks the host-consumed head.
- Drives back-pressure (almost_full), the current tail as the base address for the next PDU, and a coalescing tail doorbell to the DMA/notify engine.

Parameters:
- PDU_AWIDTH, 12, ring address width; ring depth DEPTH = 2^PDU_AWIDTH flits, one slot always left empty.
- AF_MARGIN, 64, almost_full asserts when free slots < AF_MARGIN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_data  in  514  flit_lite_t {data[511:0], sop, eop} from PDU generator
- wr_addr  in  PDU_AWIDTH  ring slot for wr_data
- wr_en  in  1  write strobe
- wr_base_addr  out  PDU_AWIDTH  committed tail; the next PDU's header slot
- almost_full  out  1  registered back-pressure
- update_valid  in  1  PDU commit strobe
- update_size  in  PDU_AWIDTH  flits in committed PDU, header included
- head_wr_valid  in  1  host head-pointer update (MMIO)
- head_wr_ptr  in  PDU_AWIDTH  new host-consumed head
- ram_wr_en  out  1  ring RAM write enable
- ram_wr_addr  out  PDU_AWIDTH  ring RAM address
- ram_wr_data  out  514  ring RAM data
- tail_valid  out  1  doorbell valid
- tail_ptr  out  PDU_AWIDTH  doorbell tail value
- tail_ready  in  1  doorbell accept
- occupancy  out  PDU_AWIDTH  (tail - head) mod DEPTH
- err_flags  out  3  sticky {head_err, commit_err, wr_addr_err}

Behaviour:
- Reset (async assert, sync release): tail = head = 0; almost_full = 0; ram_wr_en = 0; tail_valid = 0; tail_ptr = 0; err_flags = 0. ram_wr_en drops immediately when reset asserts, including mid-PDU.
- Pointer arithmetic:
  - All pointer arithmetic is mod DEPTH, PDU_AWIDTH bits, natural wrap.
  - occ = tail - head; free = DEPTH - 1 - occ.
- Write path:
  - Latency is 1 cycle: wr_en/addr/data are registered onto ram_wr_*.
  - A write is legal iff (wr_addr - tail) mod DEPTH < free.
  - An illegal write is dropped (ram_wr_en stays 0) and sets wr_addr_err.
  - Writes are not counted; they reserve nothing until commit.
- Commit:
  - On update_valid with update_size <= free: tail <= tail + update_size (wraps).
  - On update_valid with update_size > free: tail holds and commit_err sets.
  - update_size = 0: no tail change and no doorbell.
- Head update:
  - On head_wr_valid with (head_wr_ptr - head) mod DEPTH <= occ: head <= head_wr_ptr.
  - Otherwise: ignore the update and set head_err.
- Simultaneous commit and head update:
  - Legality of both is checked against current-cycle occ/free.
  - Both apply in the same cycle.
- almost_full and occupancy:
  - almost_full is registered from the next-state pointers: (DEPTH - 1 - (tail_next - head_next)) < AF_MARGIN.
  - Its value is visible the cycle after the commit or head write.
  - wr_base_addr = tail register, updated the cycle after commit.
  - occupancy = registered occ.
- Doorbell FSM:
  - IDLE: on a successful nonzero commit, go to NOTIFY; tail_valid <= 1, tail_ptr <= tail_next.
  - NOTIFY:
    - Hold tail_valid. A further commit while tail_ready = 0 overwrites tail_ptr with the newest tail (coalescing); no doorbell is lost, and intermediate tails are skipped.
    - On tail_ready with no same-cycle commit: tail_valid <= 0, return to IDLE.
    - On tail_ready with a same-cycle commit: stay in NOTIFY, tail_ptr <= new tail.
- Full ring: free = 0 means every write is illegal and almost_full = 1 (AF_MARGIN >= 1).
- Empty ring: head == tail, occ = 0; any head update other than the current head is a head_err.
- err_flags clear only on reset.

Optional Feature:
- Macro PDU_RING_STATS_EN.
- When defined:
  - Adds outputs stat_pdu_cnt[31:0] and stat_flit_cnt[31:0].
  - stat_pdu_cnt counts successful nonzero commits; stat_flit_cnt sums their update_size.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined: the ports are absent and no counter logic is built.

Test Plan:
- Reset, then one PDU: writes at addrs 1..3, update_size=4 -> ram_wr_en pulses at 1..3 one cycle later; wr_base_addr=4; tail_valid=1, tail_ptr=4; occupancy=4.
- Wrap (PDU_AWIDTH=4, DEPTH=16): head=tail=14, writes at 15,0,1, commit size 4 -> tail=2, occupancy=4, no errors.
- Full/almost_full (DEPTH=16, AF_MARGIN=4): commit 12 from empty -> free=3, almost_full=1 the next cycle. Commit 4 -> commit_err=1, tail unchanged. head_wr_ptr=+8 -> almost_full=0.
- Doorbell coalescing: tail_ready=0, three commits of size 2 from 0 -> tail_valid held, tail_ptr=6. Assert tail_ready for 1 cycle -> tail_valid=0.
- Illegal accesses: write at tail-1 -> dropped, wr_addr_err=1. head_wr_ptr beyond tail -> head_err=1, head unchanged.
- Reset mid-PDU after 2 of 3 writes -> ram_wr_en=0 immediately, tail=0, tail_valid=0; with PDU_RING_STATS_EN, counters return to 0.
